// File: rtl/period_meter_pkg.sv
// rtl/period_meter_pkg.sv - shared types and defaults for the period meter
// Purpose: measurement FSM state encoding and default parameter values.
// Ports: none (package).
package period_meter_pkg;

  localparam int CNT_W_DEF   = 31;
  localparam int TIMEOUT_DEF = 50000000;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_e;

endpackage : period_meter_pkg

// File: rtl/sync_rise_det.sv
// rtl/sync_rise_det.sv - 2-flop synchronizer with rising-edge detect
// Purpose: brings an asynchronous input into the clk domain and flags its
//          rising edges.
// Ports:
//   clk   - clock
//   rst_n - asynchronous active-low reset
//   d_in  - asynchronous input
//   level - synchronized level of d_in
//   rise  - one-cycle pulse when the synchronized level goes 0 -> 1
module sync_rise_det (
  input  logic clk,
  input  logic rst_n,
  input  logic d_in,
  output logic level,
  output logic rise
);

  logic s1_q;
  logic s2_q;
  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= d_in;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign level = s2_q;
  assign rise  = s2_q & ~prev_q;

endmodule : sync_rise_det

// File: rtl/period_meter.sv
// rtl/period_meter.sv - period and high-time meter for a slow square wave
// Purpose: counts clk cycles between rising edges of sig_in and the cycles it
//          was high, reporting both once per period; flags a lost signal.
// Optional feature: define PERIOD_METER_AVG_EN to report the average of every
//          4 consecutive raw measurements instead of each raw measurement.
// Ports:
//   clk        - clock
//   rst_n      - asynchronous active-low reset
//   sig_in     - asynchronous signal to measure
//   period     - last measured period, clk cycles
//   high_time  - clk cycles sig_in was high in that period
//   meas_valid - one-cycle pulse when period/high_time update
//   timeout    - level: no rising edge seen for TIMEOUT cycles
module period_meter
  import period_meter_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic level;
  logic rise;

  sync_rise_det u_sync_rise_det (
    .clk   (clk),
    .rst_n (rst_n),
    .d_in  (sig_in),
    .level (level),
    .rise  (rise)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;

  // Raw measurement strobe and values, consumed by the output stage.
  logic             raw_stb;
  logic             idle_entry;
  logic [CNT_W-1:0] raw_p;
  logic [CNT_W-1:0] raw_h;

  // The rise cycle itself is the last cycle of the period, hence the +1.
  assign raw_p = cnt_q + 1'b1;
  assign raw_h = hi_cnt_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hi_cnt_d   = hi_cnt_q;
    timeout_d  = timeout_q;
    raw_stb    = 1'b0;
    idle_entry = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rise) begin
          cnt_d     = '0;
          hi_cnt_d  = CNT_W'(1);
          timeout_d = 1'b0;
          state_d   = MEASURE;
        end
      end
      MEASURE: begin
        // A rise on the last allowed cycle is still a valid period.
        if (rise) begin
          raw_stb  = 1'b1;
          cnt_d    = '0;
          hi_cnt_d = CNT_W'(1);
        end else if (cnt_q == CNT_LAST) begin
          timeout_d  = 1'b1;
          idle_entry = 1'b1;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (level && (hi_cnt_q != CNT_MAX)) begin
            hi_cnt_d = hi_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef PERIOD_METER_AVG_EN
  logic [CNT_W+1:0] acc_p_q, acc_p_d;
  logic [CNT_W+1:0] acc_h_q, acc_h_d;
  logic [1:0]       acc_n_q, acc_n_d;
  logic [CNT_W+1:0] sum_p;
  logic [CNT_W+1:0] sum_h;

  assign sum_p = acc_p_q + {2'b00, raw_p};
  assign sum_h = acc_h_q + {2'b00, raw_h};

  always_comb begin
    acc_p_d  = acc_p_q;
    acc_h_d  = acc_h_q;
    acc_n_d  = acc_n_q;
    period_d = period_q;
    high_d   = high_q;
    valid_d  = 1'b0;
    if (idle_entry) begin
      acc_p_d = '0;
      acc_h_d = '0;
      acc_n_d = '0;
    end else if (raw_stb) begin
      if (acc_n_q == 2'd3) begin
        period_d = CNT_W'(sum_p >> 2);
        high_d   = CNT_W'(sum_h >> 2);
        valid_d  = 1'b1;
        acc_p_d  = '0;
        acc_h_d  = '0;
        acc_n_d  = '0;
      end else begin
        acc_p_d = sum_p;
        acc_h_d = sum_h;
        acc_n_d = acc_n_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_p_q <= '0;
      acc_h_q <= '0;
      acc_n_q <= '0;
    end else begin
      acc_p_q <= acc_p_d;
      acc_h_q <= acc_h_d;
      acc_n_q <= acc_n_d;
    end
  end
`else
  always_comb begin
    period_d = period_q;
    high_d   = high_q;
    valid_d  = raw_stb;
    if (raw_stb) begin
      period_d = raw_p;
      high_d   = raw_h;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_cnt_q  <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_cnt_q  <= hi_cnt_d;
      period_q  <= period_d;
      high_q    <= high_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign period     = period_q;
  assign high_time  = high_q;
  assign meas_valid = valid_q;
  assign timeout    = timeout_q;

endmodule : period_meter

// File: tb/tb_period_meter.sv
// tb/tb_period_meter.sv - scoreboard bench for period_meter (TIMEOUT=100, CNT_W=16)
module tb_period_meter;

  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 100;

  logic             clk;
  logic             rst_n;
  logic             sig_in;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic             timeout;

  period_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sig_in     (sig_in),
    .period     (period),
    .high_time  (high_time),
    .meas_valid (meas_valid),
    .timeout    (timeout)
  );

  typedef struct {
    int p;
    int h;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic push(input int p, input int h);
    exp_t e;
    e.p = p;
    e.h = h;
    exp_q.push_back(e);
  endtask

  // One period of sig_in: high h cycles, then low n-h cycles; called at negedge.
  task automatic per(input int n, input int h);
    sig_in = 1'b1;
    repeat (h) @(negedge clk);
    sig_in = 1'b0;
    repeat (n - h) @(negedge clk);
  endtask

  // Monitor: every meas_valid cycle must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && meas_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("period", int'(period), e.p);
        chk("high_time", int'(high_time), e.h);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    sig_in = 1'b0;
    #12;
    chk("rst_period", int'(period), 0);
    chk("rst_high", int'(high_time), 0);
    chk("rst_valid", int'(meas_valid), 0);
    chk("rst_timeout", int'(timeout), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

`ifdef PERIOD_METER_AVG_EN
    // Raw 10,11,12,13 (high 4,4,5,5) -> one result 46>>2=11, 18>>2=4.
    for (int g = 0; g < 2; g++) begin
      per(10, 4);
      per(11, 4);
      per(12, 5);
      per(13, 5);
      if (g == 0) push(11, 4);
    end
    // Second group: 10,11,12,13 measured from rise 5 .. rise 9.
    push(11, 4);
    per(10, 4);
    repeat (5) @(negedge clk);
    chk("avg_timeout_clear", int'(timeout), 0);
`else
    // Lock on 10/4: no valid on the first edge.
    for (int i = 0; i < 6; i++) begin
      if (i > 0) push(10, 4);
      per(10, 4);
    end

    // Hold low after the last rise: timeout exactly 100 cycles after detection.
    push(10, 4);
    sig_in = 1'b1;
    repeat (4) @(negedge clk);
    sig_in = 1'b0;
    repeat (98) @(negedge clk);
    chk("timeout_early", int'(timeout), 0);
    @(negedge clk);
    chk("timeout_set", int'(timeout), 1);
    chk("timeout_hold_period", int'(period), 10);
    chk("timeout_hold_high", int'(high_time), 4);
    repeat (47) @(negedge clk);

    // Resume: timeout clears on first rise, valid only from the second.
    for (int i = 0; i < 6; i++) begin
      if (i > 0) push(10, 4);
      per(10, 4);
      if (i == 0) chk("timeout_clear", int'(timeout), 0);
    end

    // Change to 20/5: the first rise closes the last 10/4 period.
    for (int i = 0; i < 4; i++) begin
      if (i == 0) push(10, 4);
      else        push(20, 5);
      per(20, 5);
    end

    // Period exactly TIMEOUT: rise coincides with cnt=99 and wins.
    push(20, 5);
    per(100, 30);
    push(100, 30);
    per(100, 30);
    push(100, 30);
    sig_in = 1'b1;
    repeat (5) @(negedge clk);
    chk("boundary_no_timeout", int'(timeout), 0);
    sig_in = 1'b0;
    repeat (120) @(negedge clk);
    chk("boundary_then_lost", int'(timeout), 1);

    // Reset mid-period.
    for (int i = 0; i < 3; i++) begin
      if (i > 0) push(10, 4);
      per(10, 4);
    end
    sig_in = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_period", int'(period), 0);
    chk("async_rst_high", int'(high_time), 0);
    chk("async_rst_valid", int'(meas_valid), 0);
    chk("async_rst_timeout", int'(timeout), 0);
    sig_in = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) push(10, 4);
      per(10, 4);
    end
    push(10, 4);
    per(10, 4);
`endif

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_period_meter
